// File: rtl/wf68k30l_prefetch_queue.sv
// Instruction prefetch queue: long-word bus fetches fill a circular buffer of
// 16-bit words that the decoder drains as operation or extension words.
module wf68k30l_prefetch_queue #(
    parameter int DEPTH = 8,
    parameter int ADR_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [ADR_W-1:0]        flush_adr,
    output logic                    bus_req,
    output logic [ADR_W-1:0]        bus_adr,
    input  logic                    bus_ack,
    input  logic [31:0]             bus_data,
    input  logic                    bus_err,
    input  logic                    ow_req,
    output logic                    ow_rdy,
    output logic [15:0]             ow_data,
    output logic [ADR_W-1:0]        ow_pc,
    input  logic                    ew_req,
    input  logic                    ew_long,
    output logic                    ew_ack,
    output logic [31:0]             ew_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    fault
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP  = (AW+1)'(DEPTH);
    localparam logic [AW:0] ZERO = '0;
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] TWO  = (AW+1)'(2);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD, HALT} state_t;

    state_t            state;
    logic [15:0]       mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr, rd_ptr1, wr_ptr1;
    logic [ADR_W-1:1]  fetch_pc;
    logic              run;
    logic [AW:0]       free, need, n_push, n_pop;
    logic              push;
    logic              unused_adr0;

    assign unused_adr0 = flush_adr[0];
    assign rd_ptr1 = rd_ptr + 1'b1;
    assign wr_ptr1 = wr_ptr + 1'b1;
    assign free    = CAP - level;
    // A fetch PC in the upper word of a long only yields one useful word.
    assign need    = fetch_pc[1] ? ONE : TWO;

    assign ow_rdy  = (level != ZERO) && !ew_req && !flush;
    assign ew_ack  = ew_req && !flush && (level >= (ew_long ? TWO : ONE));
    assign ow_data = mem[rd_ptr];
    assign ew_data = ew_long ? {mem[rd_ptr], mem[rd_ptr1]} : {16'h0000, mem[rd_ptr]};
    assign push    = (state == REQ) && bus_ack && !flush;

    always_comb begin
        n_pop  = ZERO;
        n_push = ZERO;
        if (ew_ack)
            n_pop = ew_long ? TWO : ONE;
        else if (ow_req && ow_rdy)
            n_pop = ONE;
        if (push)
            n_push = need;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            if (fetch_pc[1]) begin
                mem[wr_ptr] <= bus_data[15:0];
            end else begin
                mem[wr_ptr]  <= bus_data[31:16];
                mem[wr_ptr1] <= bus_data[15:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bus_req  <= 1'b0;
            bus_adr  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            fetch_pc <= '0;
            ow_pc    <= '0;
            run      <= 1'b0;
            fault    <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                level    <= '0;
                fetch_pc <= flush_adr[ADR_W-1:1];
                ow_pc    <= {flush_adr[ADR_W-1:1], 1'b0};
                fault    <= 1'b0;
                run      <= 1'b1;
            end else begin
                rd_ptr <= rd_ptr + n_pop[AW-1:0];
                wr_ptr <= wr_ptr + n_push[AW-1:0];
                level  <= level + n_push - n_pop;
                ow_pc  <= ow_pc + ADR_W'({n_pop, 1'b0});
                if (push)
                    fetch_pc <= {fetch_pc[ADR_W-1:2] + 1'b1, 1'b0};
                if (state == REQ && bus_err && !bus_ack)
                    fault <= 1'b1;
            end

            // Flush never cancels a bus cycle already started; it is drained in DISCARD.
            case (state)
                IDLE: if (run && !flush && free >= need) begin
                    state   <= REQ;
                    bus_req <= 1'b1;
                    bus_adr <= {fetch_pc[ADR_W-1:2], 2'b00};
                end
                REQ: if (bus_ack || bus_err) begin
                    bus_req <= 1'b0;
                    state   <= (flush || bus_ack) ? IDLE : HALT;
                end else if (flush) begin
                    state <= DISCARD;
                end
                DISCARD: if (bus_ack || bus_err) begin
                    bus_req <= 1'b0;
                    state   <= IDLE;
                end
                HALT: if (flush) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wf68k30l_prefetch_queue.sv
// Directed and randomized checks of the prefetch queue against a word-queue
// model of the instruction stream and a synthetic instruction memory.
module tb_wf68k30l_prefetch_queue;
    localparam int DEPTH = 4;
    localparam int ADR_W = 32;

    logic        clk = 1'b0, reset = 1'b1, flush = 1'b0;
    logic [31:0] flush_adr = '0, bus_data = '0;
    logic        bus_ack = 1'b0, bus_err = 1'b0;
    logic        ow_req = 1'b0, ew_req = 1'b0, ew_long = 1'b0;
    logic        bus_req, ow_rdy, ew_ack, fault;
    logic [31:0] bus_adr, ow_pc, ew_data;
    logic [15:0] ow_data;
    logic [$clog2(DEPTH):0] level;

    always #5 clk = ~clk;

    wf68k30l_prefetch_queue #(.DEPTH(DEPTH), .ADR_W(ADR_W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .flush_adr(flush_adr),
        .bus_req(bus_req), .bus_adr(bus_adr), .bus_ack(bus_ack),
        .bus_data(bus_data), .bus_err(bus_err), .ow_req(ow_req),
        .ow_rdy(ow_rdy), .ow_data(ow_data), .ow_pc(ow_pc), .ew_req(ew_req),
        .ew_long(ew_long), .ew_ack(ew_ack), .ew_data(ew_data),
        .level(level), .fault(fault)
    );

    int total = 0, bad = 0;

    // Model: the queue holds the instruction words in program order.
    logic [15:0] q[$];
    logic [31:0] hpc = '0, fpc = '0;
    bit          fault_e = 0, run_e = 0, discard = 0;
    bit          out_active = 0, err_next = 0, err_force = 0, ovr_en = 0;
    int          cnt = 0, lat = 0, lat_fix = -1;
    logic [31:0] ovr_data = '0, last_ew = '0;
    bit          last_owr = 0, last_ewa = 0;

    function automatic logic [15:0] mw(input logic [31:0] a);
        return a[16:1] ^ 16'h5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at negedge, respond on the bus, check, update model.
    task automatic tick(input bit f, input logic [31:0] fa, input bit o, input bit e, input bit l);
        bit resp, exp_owr, exp_ewa;
        int n;
        flush = f; flush_adr = fa; ow_req = o; ew_req = e; ew_long = l;
        bus_ack = 0; bus_err = 0; bus_data = '0;
        if (fault_e || !run_e) chk("no_fetch", 32'(bus_req), 0);
        if (bus_req && !out_active) begin
            out_active = 1; cnt = 0;
            lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
            err_next = err_force || (lat_fix < 0 && $urandom_range(0, 39) == 0);
            chk("bus_adr", bus_adr, {fpc[31:2], 2'b00});
        end
        if (out_active) begin
            if (cnt == lat) begin
                if (err_next) bus_err = 1;
                else begin
                    bus_ack = 1;
                    bus_data = ovr_en ? ovr_data : {mw(bus_adr), mw(bus_adr + 2)};
                end
                out_active = 0;
            end else cnt++;
        end
        #1;
        exp_owr = q.size() >= 1 && !e && !f;
        exp_ewa = e && !f && q.size() >= (l ? 2 : 1);
        chk("ow_rdy", 32'(ow_rdy), 32'(exp_owr));
        chk("ew_ack", 32'(ew_ack), 32'(exp_ewa));
        chk("level", 32'(level), 32'(q.size()));
        chk("ow_pc", ow_pc, hpc);
        chk("fault", 32'(fault), 32'(fault_e));
        if (exp_owr) chk("ow_data", 32'(ow_data), 32'(q[0]));
        if (exp_ewa) chk("ew_data", ew_data, l ? {q[0], q[1]} : {16'h0000, q[0]});
        last_ew = ew_data; last_owr = ow_rdy; last_ewa = ew_ack;

        resp = bus_ack || bus_err;
        if (!f) begin
            if (exp_ewa) n = l ? 2 : 1;
            else if (exp_owr && o) n = 1;
            else n = 0;
            repeat (n) begin void'(q.pop_front()); hpc += 2; end
        end
        if (resp) begin
            if (!f && !discard) begin
                if (bus_err) fault_e = 1;
                else begin
                    if (!fpc[1]) q.push_back(bus_data[31:16]);
                    q.push_back(bus_data[15:0]);
                    fpc = {fpc[31:2] + 30'd1, 2'b00};
                    chk("no_overflow", 32'(q.size() <= DEPTH), 1);
                end
            end
            discard = 0;
        end
        if (f) begin
            q.delete();
            hpc = {fa[31:1], 1'b0}; fpc = hpc;
            fault_e = 0; run_e = 1;
            discard = bus_req && !resp;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_until_level(input int n, input string tag);
        for (int i = 0; i < 20 && q.size() < n; i++) tick(0, 0, 0, 0, 0);
        chk(tag, 32'(q.size() >= n), 1);
    endtask

    task automatic idle_until_req(input string tag);
        for (int i = 0; i < 20 && !bus_req; i++) tick(0, 0, 0, 0, 0);
        chk(tag, 32'(bus_req), 1);
    endtask

    initial begin
        bit f, o, e, l;
        logic [31:0] fa;
        // Reset state
        @(negedge clk); #1;
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_bus_adr", bus_adr, 0);
        chk("rst_ow_rdy", 32'(ow_rdy), 0);
        chk("rst_ew_ack", 32'(ew_ack), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_ow_pc", ow_pc, 0);
        @(negedge clk); reset = 0;
        repeat (4) tick(0, 0, 0, 0, 0);

        // Sequential fill with no consumer: saturates and stops fetching
        lat_fix = 1;
        tick(1, 32'h1000, 0, 0, 0);
        repeat (12) tick(0, 0, 0, 0, 0);
        chk("sat_level", 32'(level), DEPTH);
        chk("sat_no_req", 32'(bus_req), 0);
        repeat (6) tick(0, 0, 1, 0, 0);

        // Odd-word entry point: only the low half of the long is used
        ovr_en = 1; ovr_data = 32'hAAAA_BBBB;
        tick(1, 32'h2002, 0, 0, 0);
        idle_until_level(1, "odd_fill");
        chk("odd_pc", ow_pc, 32'h2002);
        chk("odd_data", 32'(ow_data), 32'h0000_BBBB);
        idle_until_req("odd_req");
        chk("odd_next_adr", bus_adr, 32'h2004);

        // Long extension read wins over a simultaneous operation-word pop
        ovr_data = 32'h1111_2222;
        tick(1, 32'h3000, 0, 0, 0);
        idle_until_level(2, "ew_fill");
        tick(0, 0, 1, 1, 1);
        chk("ew_long_data", last_ew, 32'h1111_2222);
        chk("ew_long_ack", 32'(last_ewa), 1);
        chk("ew_long_owrdy", 32'(last_owr), 0);
        ovr_en = 0;

        // Flush while a fetch is outstanding; its data arrives 3 cycles later
        tick(1, 32'h4000, 0, 0, 0);
        lat_fix = 4;
        for (int i = 0; i < 20 && !out_active; i++) tick(0, 0, 0, 0, 0);
        chk("disc_fetch_seen", 32'(out_active), 1);
        tick(1, 32'h5006, 0, 0, 0);
        lat_fix = 1;
        for (int i = 0; i < 20 && !(bus_req && !out_active); i++) tick(0, 0, 0, 0, 0);
        chk("disc_new_adr", bus_adr, 32'h5004);
        idle_until_level(1, "disc_fill");
        chk("disc_data", 32'(ow_data), 32'(mw(32'h5006)));

        // Bus error halts fetching until the next flush
        tick(1, 32'h6000, 0, 0, 0);
        err_force = 1;
        for (int i = 0; i < 20 && !fault_e; i++) tick(0, 0, 0, 0, 0);
        err_force = 0;
        repeat (5) tick(0, 0, 0, 0, 0);
        chk("err_fault", 32'(fault), 1);
        chk("err_no_req", 32'(bus_req), 0);
        tick(1, 32'h7000, 0, 0, 0);
        chk("err_fault_clr", 32'(fault), 0);
        idle_until_req("err_resume");
        chk("err_resume_adr", bus_adr, 32'h7000);

        // Reset in the middle of a fetch abandons it
        lat_fix = 10;
        tick(1, 32'h8000, 0, 0, 0);
        for (int i = 0; i < 20 && !out_active; i++) tick(0, 0, 0, 0, 0);
        reset = 1; flush = 0; ow_req = 0; ew_req = 0; bus_ack = 0; bus_err = 0;
        #1;
        chk("midrst_req", 32'(bus_req), 0);
        chk("midrst_level", 32'(level), 0);
        chk("midrst_pc", ow_pc, 0);
        @(negedge clk); reset = 0;
        q.delete(); hpc = '0; fpc = '0; fault_e = 0; run_e = 0;
        discard = 0; out_active = 0; lat_fix = -1;
        repeat (3) tick(0, 0, 0, 0, 0);

        // Random traffic: many wraps of the small buffer, random flushes and errors
        tick(1, 32'h9000, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            f  = ($urandom_range(0, 59) == 0);
            fa = $urandom & 32'h000F_FFFE;
            o  = $urandom_range(0, 1) == 1;
            e  = ($urandom_range(0, 3) == 0);
            l  = $urandom_range(0, 1) == 1;
            tick(f, fa, o, e, l);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
